// File: rtl/ex.sv
// Registered binary-to-one-hot decoder with enable and asynchronous clear.
// Optional one-hot integrity checker (err port) is built when EX_ONEHOT_CHK_EN is defined.
module ex #(
  parameter int N = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    a,
  input  logic            en,
`ifdef EX_ONEHOT_CHK_EN
  output logic [2**N-1:0] d,
  output logic            err
`else
  output logic [2**N-1:0] d
`endif
);

  localparam int W = 2**N;

  logic [W-1:0] dec_d;
  logic [W-1:0] dec_q;

  function automatic logic [W-1:0] decode(input logic [N-1:0] idx);
    logic [W-1:0] r;
    r = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

  always_comb begin
    dec_d = '0;
    if (en) dec_d = decode(a);
  end

  // Decode register: the only path from a/en to d
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dec_q <= '0;
    else        dec_q <= dec_d;
  end

  assign d = dec_q;

`ifdef EX_ONEHOT_CHK_EN
  logic            err_d;
  logic            err_q;
  logic [N:0]      pop;

  function automatic logic [N:0] popcount(input logic [W-1:0] v);
    logic [N:0] c;
    c = '0;
    for (int i = 0; i < W; i++) c = c + {{N{1'b0}}, v[i]};
    return c;
  endfunction

  // More than one bit high is the only illegal shape; all-zero is legal (en=0)
  always_comb begin
    pop   = popcount(dec_q);
    err_d = err_q | (pop > 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_ex.sv
// Self-checking bench for ex: directed scenarios plus randomized stimulus against a reference model.
// Checker scenario is compiled in when EX_ONEHOT_CHK_EN is defined.
module tb_ex;

  localparam int N = 3;
  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] a;
  logic         en;
  logic [W-1:0] d;
`ifdef EX_ONEHOT_CHK_EN
  logic         err;
`endif

  int vectors;
  int miscompares;

  ex #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .en    (en),
`ifdef EX_ONEHOT_CHK_EN
    .d     (d),
    .err   (err)
`else
    .d     (d)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: enabled select index as a power of two, else zero
  function automatic logic [W-1:0] ref_dec(input int idx, input bit e);
    int v;
    v = e ? (2 ** idx) : 0;
    return v[W-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; a = 3'b101;
    #3;
    vectors++;
    if (d !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_async got=%h want=%h", d, 8'h00);
    end
    repeat (3) tick();
    vectors++;
    if (d !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_hold got=%h want=%h", d, 8'h00);
    end
    rst_n = 1'b1;
    tick();
    vectors++;
    if (d !== 8'h20) begin
      miscompares++;
      $display("FAIL reset_release got=%h want=%h", d, 8'h20);
    end
  endtask

  task automatic test_sweep();
    logic [W-1:0] exp;
    en = 1'b1;
    for (int i = 0; i < W; i++) begin
      a = i[N-1:0];
      tick();
      exp = ref_dec(i, 1'b1);
      vectors++;
      if (d !== exp) begin
        miscompares++;
        $display("FAIL sweep a=%0d got=%h want=%h", i, d, exp);
      end
`ifdef EX_ONEHOT_CHK_EN
      vectors++;
      if (err !== 1'b0) begin
        miscompares++;
        $display("FAIL sweep_err a=%0d got=%b want=0", i, err);
      end
`endif
    end
  endtask

  task automatic test_enable();
    en = 1'b0; a = 3'b011;
    tick();
    vectors++;
    if (d !== 8'h00) begin
      miscompares++;
      $display("FAIL enable_off got=%h want=%h", d, 8'h00);
    end
    en = 1'b1;
    tick();
    vectors++;
    if (d !== 8'h08) begin
      miscompares++;
      $display("FAIL enable_on got=%h want=%h", d, 8'h08);
    end
    en = 1'b0;
    tick();
    vectors++;
    if (d !== 8'h00) begin
      miscompares++;
      $display("FAIL enable_drop got=%h want=%h", d, 8'h00);
    end
  endtask

  task automatic test_async_reset();
    en = 1'b1; a = 3'b110;
    tick();
    vectors++;
    if (d !== 8'h40) begin
      miscompares++;
      $display("FAIL midrst_pre got=%h want=%h", d, 8'h40);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (d !== 8'h00) begin
      miscompares++;
      $display("FAIL midrst_clear got=%h want=%h", d, 8'h00);
    end
    tick();
    #2 rst_n = 1'b1;
    tick();
    vectors++;
    if (d !== 8'h40) begin
      miscompares++;
      $display("FAIL midrst_reload got=%h want=%h", d, 8'h40);
    end
  endtask

  task automatic test_wrap();
    en = 1'b1; a = 3'b111;
    tick();
    vectors++;
    if (d !== 8'h80) begin
      miscompares++;
      $display("FAIL wrap_msb got=%h want=%h", d, 8'h80);
    end
    a = 3'b000;
    tick();
    vectors++;
    if (d !== 8'h01) begin
      miscompares++;
      $display("FAIL wrap_lsb got=%h want=%h", d, 8'h01);
    end
  endtask

  task automatic test_hold();
    en = 1'b1; a = 3'b010;
    tick();
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 3; j++) begin
        #2;
        vectors++;
        if (d !== 8'h04) begin
          miscompares++;
          $display("FAIL hold cyc=%0d got=%h want=%h", i, d, 8'h04);
        end
      end
      tick();
    end
  endtask

  // Inputs wobble mid-cycle; only the value present at the edge must count
  task automatic test_random();
    int           ai;
    bit           ei;
    logic [W-1:0] exp;
    for (int i = 0; i < 200; i++) begin
      a  = N'($urandom_range(0, W - 1));
      en = 1'($urandom_range(0, 1));
      #2;
      ai = $urandom_range(0, W - 1);
      ei = ($urandom_range(0, 3) != 0);
      a  = ai[N-1:0];
      en = ei;
      tick();
      exp = ref_dec(ai, ei);
      vectors++;
      if (d !== exp) begin
        miscompares++;
        $display("FAIL random i=%0d a=%0d en=%0d got=%h want=%h", i, ai, ei, d, exp);
      end
    end
  endtask

`ifdef EX_ONEHOT_CHK_EN
  task automatic test_onehot_chk();
    en = 1'b1; a = 3'b001;
    tick();
    force dut.dec_q = 8'h03;
    tick();
    release dut.dec_q;
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL chk_set got=%b want=1", err);
    end
    repeat (3) tick();
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL chk_sticky got=%b want=1", err);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL chk_reset got=%b want=0", err);
    end
    rst_n = 1'b1;
    repeat (2) tick();
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL chk_clean got=%b want=0", err);
    end
  endtask
`endif

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0; en = 1'b0; a = '0;
    test_reset();
    test_sweep();
    test_enable();
    test_async_reset();
    test_wrap();
    test_hold();
    test_random();
`ifdef EX_ONEHOT_CHK_EN
    test_onehot_chk();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
